// File: rtl/pipe_fifo_if.sv
// Handshake bundle between the issuer/delay-line side and pipe_fifo.
// The slave modport is the buffer; master is the issuer plus consumer.
interface pipe_fifo_if #(
    parameter int BITDATA = 8,
    parameter int DEPTH   = 8
);
    logic                     issue;
    logic                     can_issue;
    logic [BITDATA-1:0]       din;
    logic                     din_vld;
    logic [BITDATA-1:0]       dout;
    logic                     dout_vld;
    logic                     dout_rdy;
    logic [$clog2(DEPTH):0]   count;
    logic [1:0]               err;

    modport master (
        output issue, din, din_vld, dout_rdy,
        input  can_issue, dout, dout_vld, count, err
    );

    modport slave (
        input  issue, din, din_vld, dout_rdy,
        output can_issue, dout, dout_vld, count, err
    );
endinterface

// File: rtl/pipe_fifo.sv
// Credit-managed FWFT elastic buffer behind a fixed-latency delay line.
// Define PIPE_FIFO_ERR_EN to build the sticky err[1:0] detection logic.
module pipe_fifo #(
    parameter int BITDATA = 8,
    parameter int DEPTH   = 8,
    parameter int DELAY   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    pipe_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [RW-1:0] RESV_FULL = RW'(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("pipe_fifo: DEPTH must be a power of two >= 2");
        end
        if (DELAY < 0) begin : g_bad_delay
            $error("pipe_fifo: DELAY must be non-negative");
        end
    endgenerate

    logic [BITDATA-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wptr_q, wptr_d;
    logic [AW-1:0]      rptr_q, rptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [RW-1:0]      resv_q, resv_d;

    logic               dout_vld;
    logic               can_issue;
    logic               pop;
    logic               push;
    logic               full;
    logic               issue_ok;

    // Credit and occupancy are both decoded from flops so can_issue and
    // dout_vld carry no combinational path from the inputs.
    assign dout_vld  = (count_q != '0);
    assign can_issue = (resv_q < RESV_FULL);
    assign full      = (count_q == CNT_FULL);

    always_comb begin
        pop      = dout_vld && bus.dout_rdy;
        push     = bus.din_vld && (!full || pop);
        issue_ok = bus.issue && can_issue;
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // An issue reserves a slot for a word still inside the delay line; the
    // pop that frees a stored word hands that credit back.
    always_comb begin
        resv_d = resv_q;
        if (issue_ok && !pop) begin
            if (resv_q != RESV_FULL) begin
                resv_d = resv_q + RW'(1);
            end
        end else if (pop && !issue_ok) begin
            if (resv_q != '0) begin
                resv_d = resv_q - RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= bus.din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            resv_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            resv_q  <= resv_d;
        end
    end

`ifdef PIPE_FIFO_ERR_EN
    logic [1:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (bus.issue && !can_issue) begin
            err_d[0] = 1'b1;
        end
        if (bus.din_vld && full && !pop) begin
            err_d[1] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 2'b00;
`endif

    assign bus.dout      = mem_q[rptr_q];
    assign bus.dout_vld  = dout_vld;
    assign bus.can_issue = can_issue;
    assign bus.count     = count_q;
endmodule

// File: doc/pipe_fifo.md
# pipe_fifo

Credit-managed elastic buffer that sits directly downstream of the `shift` fixed-latency delay line and absorbs its output when the consumer stalls. The upstream issuer launches a word into `shift` only while `can_issue` is high; `pipe_fifo` reserves a slot at issue time, so words arriving `DELAY` cycles later never find the buffer full. Data leaves through a first-word-fall-through valid/ready port.

## Interface
- `BITDATA`, 8, width of `din`/`dout`; must match the upstream `shift`.
- `DEPTH`, 8, buffer entries; power of two, >= 2.
- `DELAY`, 0, latency of the upstream `shift`; informational only, no internal dependence.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `issue`  in  1  upstream launches one word into `shift` this cycle.
- `can_issue`  out  1  a slot is free to reserve.
- `din`  in  BITDATA  data from `shift`.
- `din_vld`  in  1  `din` valid (the `issue` strobe delayed by DELAY).
- `dout`  out  BITDATA  head-of-buffer data.
- `dout_vld`  out  1  buffer non-empty.
- `dout_rdy`  in  1  consumer accepts `dout` this cycle.
- `count`  out  $clog2(DEPTH)+1  stored entries.
- `err`  out  2  sticky: [0] issue without credit, [1] push into full buffer.

## Operation
- Storage: register array `DEPTH` x `BITDATA`; write/read pointers of $clog2(DEPTH) bits, wrap modulo DEPTH; occupancy `count` 0..DEPTH.
- Push: `din_vld` && (`count` < DEPTH || pop). Pop: `dout_vld` && `dout_rdy`.
- Simultaneous push and pop: both happen; `count` unchanged; legal when full and when at count 1.
- `dout = mem[rptr]`; unspecified (not X-checked) when empty.
- Credit counter `resv`, range 0..DEPTH, width $clog2(DEPTH+1): counts stored + in-flight words. +1 on accepted issue, −1 on pop, net 0 if both.
- `can_issue = (resv < DEPTH)`, decoded from registers only.
- `issue` while `can_issue` low: ignored by `resv`; sets `err[0]`.
- `din_vld` with `count == DEPTH` and no pop: word dropped, pointers/`count` unchanged; sets `err[1]`.
- `resv` saturates at DEPTH and 0; never wraps.
- Reset (any time, including mid-stream): pointers 0, `count` 0, `resv` 0, `err` 0, so `dout_vld` 0 and `can_issue` 1. Words in flight in `shift` at reset are not tracked; issuer must not launch until reset released.

## Timing
- Issue at edge t: `resv` updated at t+1; `can_issue` reflects it at t+1.
- Pop at t: credit returned, `can_issue` may rise at t+1.
- Push at t into empty buffer: `dout_vld` 1 at t+1 (no same-cycle bypass).
- Issue-to-`dout_vld` latency: DELAY+1 cycles with empty buffer.
- Full-rate streaming: with `dout_rdy` held 1, one issue per cycle is sustained indefinitely for any DEPTH >= DELAY+2.
- `err` bits set one cycle after the offending event; clear only by reset.

## Configuration
- `PIPE_FIFO_ERR_EN` defined: `err` logic built as described.
- Not defined: no error detection logic; `err` tied to 2'b00; all other behaviour identical (illegal pushes still dropped, illegal issues still ignored).

## Test plan
- Reset mid-traffic (count 3, resv 5) -> next cycle `count`=0, `dout_vld`=0, `can_issue`=1, `err`=0.
- DEPTH=4, DELAY=3, `dout_rdy`=0, issue every cycle while `can_issue` -> exactly 4 issues accepted, `can_issue` low after 4th, 4 words 0xA0..0xA3 stored, no `err`.
- Same state, pulse `dout_rdy` once -> 0xA0 popped, `can_issue` high next cycle, one further issue accepted, data order preserved 0xA1..0xA4.
- DEPTH=8, DELAY=2, continuous issue and `dout_rdy`=1 for 100 cycles -> 100 words out in order, first `dout_vld` 3 cycles after first issue, `can_issue` never drops.
- Full buffer, `din_vld` and `dout_rdy` same cycle -> push and pop both occur, `count` stays 8, `err` 0.
- Force `issue` while `can_issue`=0, and `din_vld` into full buffer with `dout_rdy`=0 -> `err`=2'b11 with macro defined, 2'b00 without; `count` and data unchanged in both builds.
